// File: rtl/shift_arbiter.sv
// Two-lane round-robin arbiter feeding a shared 32-bit SRL/SLL/SRA unit with one registered output slot.
// Optional saturating grant/conflict counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter #(
    parameter int TAG_W  = 6,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [1:0]        req_op_0,
    input  logic [1:0]        req_op_1,
    input  logic [31:0]       req_a_0,
    input  logic [31:0]       req_a_1,
    input  logic [31:0]       req_b_0,
    input  logic [31:0]       req_b_1,
    input  logic [TAG_W-1:0]  req_tag_0,
    input  logic [TAG_W-1:0]  req_tag_1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_lane,
    output logic              res_illegal,
    output logic [STAT_W-1:0] stat_grant_0,
    output logic [STAT_W-1:0] stat_grant_1,
    output logic [STAT_W-1:0] stat_conflict
);

    logic             prio;
    logic             can_accept;
    logic             gnt_0, gnt_1, gnt, sel;
    logic [1:0]       op;
    logic [31:0]      a;
    logic [4:0]       amt;
    logic [TAG_W-1:0] tag;
    logic [31:0]      shres;
    logic             illegal;
    logic             unused_b;

    assign unused_b = ^{req_b_0[31:5], req_b_1[31:5]};

    // Grants are masked during reset so nothing is handed out while state is being cleared.
    assign can_accept  = !flush && (!res_valid || res_ready);
    assign gnt_0       = !rst && can_accept && req_valid_0 && (!req_valid_1 || !prio);
    assign gnt_1       = !rst && can_accept && req_valid_1 && (!req_valid_0 || prio);
    assign gnt         = gnt_0 || gnt_1;
    assign sel         = gnt_1;
    assign req_ready_0 = gnt_0;
    assign req_ready_1 = gnt_1;

    always_comb begin
        op      = sel ? req_op_1  : req_op_0;
        a       = sel ? req_a_1   : req_a_0;
        amt     = sel ? req_b_1[4:0] : req_b_0[4:0];
        tag     = sel ? req_tag_1 : req_tag_0;
        shres   = 32'd0;
        illegal = 1'b0;
        case (op)
            2'b00:   shres = a >> amt;
            2'b10:   shres = a << amt;
            2'b01:   shres = $signed(a) >>> amt;
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_tag     <= '0;
            res_lane    <= 1'b0;
            res_illegal <= 1'b0;
            prio        <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (gnt) begin
            res_valid   <= 1'b1;
            res_data    <= shres;
            res_tag     <= tag;
            res_lane    <= sel;
            res_illegal <= illegal;
            prio        <= ~sel;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_g0, cnt_g1, cnt_cf;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_g0 <= '0;
            cnt_g1 <= '0;
            cnt_cf <= '0;
        end else begin
            if (gnt_0 && cnt_g0 != '1) cnt_g0 <= cnt_g0 + 1'b1;
            if (gnt_1 && cnt_g1 != '1) cnt_g1 <= cnt_g1 + 1'b1;
            if (gnt && req_valid_0 && req_valid_1 && cnt_cf != '1) cnt_cf <= cnt_cf + 1'b1;
        end
    end

    assign stat_grant_0  = cnt_g0;
    assign stat_grant_1  = cnt_g1;
    assign stat_conflict = cnt_cf;
`else
    assign stat_grant_0  = '0;
    assign stat_grant_1  = '0;
    assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a reference model predicts grants and queues expected
// results; an independent monitor compares the output slot against the queue head.
module tb_shift_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        lane;
        logic        ill;
    } item_t;

`ifdef SHIFT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, res_ready;
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic [5:0]  tag0, tag1;
    logic [31:0] e0, e1;
    logic        il0, il1;
    logic        req_ready_0, req_ready_1, res_valid, res_lane, res_illegal;
    logic [31:0] res_data;
    logic [5:0]  res_tag;
    logic [15:0] stat_grant_0, stat_grant_1, stat_conflict;

    item_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  mv = 1'b0;
    logic  pm = 1'b0;

    always #5 clk = ~clk;

    shift_arbiter #(.TAG_W(6), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid_0(v0), .req_valid_1(v1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_op_0(op0), .req_op_1(op1),
        .req_a_0(a0), .req_a_1(a1),
        .req_b_0(b0), .req_b_1(b1),
        .req_tag_0(tag0), .req_tag_1(tag1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .res_lane(res_lane), .res_illegal(res_illegal),
        .stat_grant_0(stat_grant_0), .stat_grant_1(stat_grant_1),
        .stat_conflict(stat_conflict)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int l, input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp,
                        input logic ill);
        if (l == 0) begin
            v0 = v; op0 = op; a0 = a; b0 = b; tag0 = tag; e0 = exp; il0 = ill;
        end else begin
            v1 = v; op1 = op; a1 = a; b1 = b; tag1 = tag; e1 = exp; il1 = ill;
        end
    endtask

    // Reference model: predict grants at the sampling point, update queue and slot state at the edge.
    always @(negedge clk) begin
        logic g0, g1, ca;
        ca = !rst && !flush && (!mv || res_ready);
        g0 = ca && v0 && (!v1 || !pm);
        g1 = ca && v1 && (!v0 || pm);
        chk("req_ready_0", {63'd0, req_ready_0}, {63'd0, g0});
        chk("req_ready_1", {63'd0, req_ready_1}, {63'd0, g1});
        chk("res_valid", {63'd0, res_valid}, {63'd0, mv});
        @(posedge clk);
        if (rst || flush) exp_q.delete();
        if (g0) exp_q.push_back('{data: e0, tag: tag0, lane: 1'b0, ill: il0});
        if (g1) exp_q.push_back('{data: e1, tag: tag1, lane: 1'b1, ill: il1});
        if (rst || flush)          mv = 1'b0;
        else if (g0 || g1)         mv = 1'b1;
        else if (mv && res_ready)  mv = 1'b0;
        if (rst)     pm = 1'b0;
        else if (g0) pm = 1'b1;
        else if (g1) pm = 1'b0;
    end

    // Monitor: whatever the slot shows must match the queue head; pop on a real drain.
    always @(negedge clk) begin
        item_t it;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected", {63'd0, res_valid}, 64'd0);
            end else begin
                it = exp_q[0];
                chk("res_payload", {23'd0, res_data, res_tag, res_lane, res_illegal},
                    {23'd0, it.data, it.tag, it.lane, it.ill});
                if (res_ready && !flush && !rst) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_data"}, {32'd0, res_data}, 64'd0);
        chk({pfx, "_tag"}, {58'd0, res_tag}, 64'd0);
        chk({pfx, "_lane"}, {63'd0, res_lane}, 64'd0);
        chk({pfx, "_ill"}, {63'd0, res_illegal}, 64'd0);
        chk({pfx, "_stats"}, {16'd0, stat_grant_0, stat_grant_1, stat_conflict}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
        lane(0, 0, 2'b00, 0, 0, 0, 0, 0);
        lane(1, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        cyc();

        // Lane 0 alone: SLL 1 by 3; then both valid must favour lane 1.
        lane(0, 1, 2'b10, 32'h0000_0001, 32'h0000_0023, 6'd5, 32'h0000_0008, 0);
        cyc();
        lane(0, 1, 2'b00, 32'h0000_00F0, 32'd4, 6'd1, 32'h0000_000F, 0);
        lane(1, 1, 2'b10, 32'h0000_00F0, 32'd4, 6'd2, 32'h0000_0F00, 0);
        cyc();
        v0 = 0; v1 = 0;
        cyc();

        // Back-to-back alternation from a clean reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        v0 = 1; v1 = 1;
        repeat (8) cyc();
        v0 = 0; v1 = 0;
        cyc();
        @(negedge clk);
        chk("stat_grant_0", {48'd0, stat_grant_0}, STATS ? 64'd4 : 64'd0);
        chk("stat_grant_1", {48'd0, stat_grant_1}, STATS ? 64'd4 : 64'd0);
        chk("stat_conflict", {48'd0, stat_conflict}, STATS ? 64'd8 : 64'd0);
        cyc();

        // Datapath corners.
        lane(0, 1, 2'b01, 32'h8000_0000, 32'd31, 6'd10, 32'hFFFF_FFFF, 0);
        cyc();
        lane(0, 1, 2'b00, 32'h8000_0000, 32'd31, 6'd11, 32'h0000_0001, 0);
        cyc();
        lane(0, 1, 2'b11, 32'h0000_1234, 32'd3, 6'd12, 32'h0000_0000, 1);
        cyc();
        v0 = 0;
        cyc();

        // Backpressure: one grant fills the slot, three blocked cycles, then grant on drain.
        res_ready = 1'b0;
        lane(0, 1, 2'b10, 32'h0000_0001, 32'd1, 6'd20, 32'h0000_0002, 0);
        lane(1, 1, 2'b00, 32'h0000_0100, 32'd8, 6'd21, 32'h0000_0001, 0);
        repeat (4) cyc();
        res_ready = 1'b1;
        cyc();
        v0 = 0; v1 = 0;
        repeat (2) cyc();

        // Flush with a held result and both lanes requesting.
        res_ready = 1'b0;
        v0 = 1; v1 = 1;
        cyc();
        res_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        v0 = 0; v1 = 0;
        repeat (2) cyc();

        // Reset between grant and drain.
        res_ready = 1'b0;
        lane(0, 1, 2'b10, 32'h0000_0003, 32'd2, 6'd30, 32'h0000_000C, 0);
        cyc();
        v0 = 0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        repeat (2) cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-lane arbiter and sequencer for the shared 32-bit shift datapath of the dual-issue integer pipeline. Each issue lane presents shift requests over a valid/ready handshake. The block grants at most one per cycle using round-robin priority and performs SRL/SLL/SRA on the granted operands. It holds the result in a single registered output slot with backpressure, tagged with lane and tag, for the writeback stage.

## Interface
- `TAG_W`, 6: width of the per-request tag (ROB/destination id).
- `STAT_W`, 16: width of the statistics counters.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush; kills the held result and blocks grants this cycle.
- `req_valid_0`, `req_valid_1` in 1: lane request valid.
- `req_ready_0`, `req_ready_1` out 1: lane request accepted (grant) this cycle.
- `req_op_0`, `req_op_1` in 2: shift op; 00 = SRL, 10 = SLL, 01 = SRA, 11 = illegal.
- `req_a_0`, `req_a_1` in 32: operand to shift.
- `req_b_0`, `req_b_1` in 32: shift amount source; only bits [4:0] are used.
- `req_tag_0`, `req_tag_1` in TAG_W: request tag.
- `res_valid` out 1: output slot holds a result.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 32: shift result.
- `res_tag` out TAG_W: tag of the result.
- `res_lane` out 1: lane that issued the result.
- `res_illegal` out 1: op was 11; `res_data` is 0.
- `stat_grant_0`, `stat_grant_1` out STAT_W: grant counts per lane.
- `stat_conflict` out STAT_W: count of cycles where both lanes requested and one was granted.

## Operation
- `can_accept = !flush & (!res_valid | res_ready)`.
- Priority pointer `prio` (1 bit) selects the favoured lane.
  - If both lanes are valid and `can_accept` is high, the lane equal to `prio` is granted.
  - If one lane is valid and `can_accept` is high, that lane is granted regardless of `prio`.
- At most one `req_ready_*` is high in any cycle.
- `req_ready_x` is combinational from valids, `prio`, `flush`, `res_valid` and `res_ready`. Requesters must not make valid depend on ready.
- On a grant to lane g: `prio <= ~g`. The pointer is unchanged when there is no grant.
- Once asserted, a request's valid and payload must hold until ready. The block never drops an un-granted request.
- Datapath:
  - SRL: `A >> B[4:0]`.
  - SLL: `A << B[4:0]`.
  - SRA: `A` shifted right arithmetically by `B[4:0]`, sign-filled from A[31].
  - op 11: result 0 and `res_illegal` = 1.
- Output slot update:
  - On a grant, the slot loads `{data, tag, lane, illegal}` and `res_valid` goes to 1.
  - If the slot is draining (`res_valid & res_ready`) with no new grant, `res_valid` goes to 0.
  - Simultaneous drain and grant: the slot loads the new result and `res_valid` stays 1.
- `flush`:
  - Next cycle `res_valid` = 0, even if `res_ready` was high.
  - No grant occurs in the flush cycle.
  - `prio` is unchanged.
- Reset values:
  - `res_valid` = 0, `res_data` = 0, `res_tag` = 0, `res_lane` = 0, `res_illegal` = 0.
  - `prio` = 0.
  - All stat counters = 0.
  - `req_ready_*` = 0 while `rst` is high.
- Reset mid-transaction discards the held result and any pending grant.

## Timing
- Latency is 1 cycle: granted in cycle N, `res_valid` with the result in cycle N+1.
- Throughput is 1 result/cycle while `res_ready` is held high.
- With `res_ready` low and `res_valid` high, there are no grants. The output slot and `prio` hold their values.
- Output payload is stable while `res_valid & !res_ready`.
- Stat counters update in the grant cycle and are visible at N+1. They saturate at all-ones and do not wrap.

## Configuration
- `SHIFT_ARB_STATS_EN`:
  - Defined: `stat_grant_0`, `stat_grant_1` and `stat_conflict` count as specified, saturating, and are cleared by `rst` only (not by `flush`).
  - Undefined: the counters are not built and the three ports are tied to 0. Arbitration and datapath behaviour are identical.

## Test plan
- Reset, then lane 0 only: op=10, A=0x0000_0001, B=0x0000_0023 (amount 3) -> `req_ready_0`=1 in N; at N+1 `res_data`=0x0000_0008, `res_lane`=0, `res_tag` equals the request tag; then `prio`=1.
- Both lanes valid every cycle, `res_ready`=1 -> grants alternate 0,1,0,1 starting with lane 0. Over 8 cycles `stat_grant_0`=4, `stat_grant_1`=4, `stat_conflict`=8 with the macro defined, 0 without.
- SRA A=0x8000_0000, B=31 -> 0xFFFF_FFFF. SRL with the same operands -> 0x0000_0001. op=11 -> `res_data`=0 and `res_illegal`=1.
- Backpressure: hold `res_ready`=0 for 3 cycles with both lanes valid -> no `req_ready`, result stable. On the cycle `res_ready` rises, a new grant occurs and `res_valid` stays 1 with new data at the next cycle.
- Flush with `res_valid`=1 and both lanes valid -> no grant that cycle, `res_valid`=0 next cycle, `prio` unchanged, and the next grant follows `prio`.
- Assert `rst` for one cycle between a grant and its drain -> all outputs return to their reset values the next cycle. The pending result never appears on `res_valid`.
